// File: rtl/vx_barrier_unit_pkg.sv
// rtl/vx_barrier_unit_pkg.sv - shared barrier types, error codes and width helper
package vx_barrier_unit_pkg;

   // Error codes reported on err_code alongside a one-cycle err_valid pulse.
   localparam logic [1:0] BAR_ERR_NONE = 2'b00;
   localparam logic [1:0] BAR_ERR_DUP  = 2'b01;
   localparam logic [1:0] BAR_ERR_SIZE = 2'b10;

   // Widths of the default core configuration (4 warps, 4 barriers).
   localparam int BAR_DEF_NW_BITS = 2;
   localparam int BAR_DEF_NB_BITS = 2;
   localparam int BAR_DEF_WARPS   = 4;

   // Index width that never collapses to zero bits for a single-element range.
   function automatic int up_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Barrier request as issued by the GPU unit (default configuration widths).
   typedef struct packed {
      logic                       valid;
      logic [BAR_DEF_NB_BITS-1:0] id;
      logic [BAR_DEF_NW_BITS-1:0] size_m1;
      logic                       noblock;
      logic [BAR_DEF_NW_BITS-1:0] wid;
   } gpu_barrier_t;

   // State of one barrier slot (default configuration widths).
   typedef struct packed {
      logic                       active;
      logic [BAR_DEF_NW_BITS-1:0] size_m1;
      logic [BAR_DEF_WARPS-1:0]   mask;
      logic [BAR_DEF_WARPS-1:0]   wait_mask;
      logic [BAR_DEF_NW_BITS:0]   count;
   } barrier_entry_t;

endpackage

// File: rtl/vx_barrier_unit_entry.sv
// rtl/vx_barrier_unit_entry.sv - one barrier slot: arrival tracking, release and error flags
module vx_barrier_unit_entry
   import vx_barrier_unit_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = up_clog2(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sel,
   input  logic [NW_BITS-1:0]   req_wid,
   input  logic [NW_BITS-1:0]   req_size_m1,
   input  logic                 req_noblock,
   output logic [NUM_WARPS-1:0] wait_mask,
   output logic                 rel_valid,
   output logic [NUM_WARPS-1:0] rel_wmask,
   output logic                 err_dup,
   output logic                 err_size
);

   localparam logic [NW_BITS:0] CNT_ONE = (NW_BITS+1)'(1);

   logic                 active;
   logic [NW_BITS-1:0]   size_m1;
   logic [NUM_WARPS-1:0] mask;
   logic [NW_BITS:0]     count;

   logic [NUM_WARPS-1:0] wid_bit;
   logic [NW_BITS-1:0]   eff_size;
   logic [NW_BITS:0]     count_next;
   logic [NW_BITS:0]     target;
   logic [NUM_WARPS-1:0] wait_next;
   logic                 arrive;
   logic                 is_final;

   // Classify the incoming request: duplicate, size mismatch, plain or final arrival.
   always_comb begin
      wid_bit          = '0;
      wid_bit[req_wid] = 1'b1;
      err_dup          = sel && active && ((mask & wid_bit) != '0);
      err_size         = sel && active && !err_dup && (size_m1 != req_size_m1);
      // The first arrival defines the generation's size; later ones are forced to it.
      eff_size         = active ? size_m1 : req_size_m1;
      arrive           = sel && !err_dup;
      count_next       = count + CNT_ONE;
      // Zero-extended compare keeps size_m1 = NUM_WARPS-1 from overflowing.
      target           = {1'b0, eff_size} + CNT_ONE;
      is_final         = arrive && (count_next == target);
      wait_next        = req_noblock ? wait_mask : (wait_mask | wid_bit);
   end

   // Slot state update; the final arrival clears the slot and launches the release pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         active    <= 1'b0;
         size_m1   <= '0;
         mask      <= '0;
         wait_mask <= '0;
         count     <= '0;
         rel_valid <= 1'b0;
         rel_wmask <= '0;
      end else begin
         rel_valid <= is_final;
         rel_wmask <= is_final ? wait_next : '0;
         if (is_final) begin
            active    <= 1'b0;
            size_m1   <= '0;
            mask      <= '0;
            wait_mask <= '0;
            count     <= '0;
         end else if (arrive) begin
            active    <= 1'b1;
            size_m1   <= eff_size;
            mask      <= mask | wid_bit;
            wait_mask <= wait_next;
            count     <= count_next;
         end
      end
   end

endmodule

// File: rtl/vx_barrier_unit.sv
// rtl/vx_barrier_unit.sv - per-core warp barrier controller; optional perf counters via BARRIER_PERF_EN
module vx_barrier_unit
   import vx_barrier_unit_pkg::*;
#(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4,
   parameter int NW_BITS      = up_clog2(NUM_WARPS),
   parameter int NB_BITS      = up_clog2(NUM_BARRIERS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [NB_BITS-1:0]   req_id,
   input  logic [NW_BITS-1:0]   req_wid,
   input  logic [NW_BITS-1:0]   req_size_m1,
   input  logic                 req_noblock,
   output logic                 release_valid,
   output logic [NUM_WARPS-1:0] release_wmask,
   output logic [NUM_WARPS-1:0] stalled_wmask,
   output logic                 err_valid,
   output logic [1:0]           err_code
`ifdef BARRIER_PERF_EN
   ,
   output logic [63:0]          perf_stall_cycles,
   output logic [31:0]          perf_releases
`endif
);

   logic [NUM_WARPS-1:0] ent_wait  [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] ent_rmask [NUM_BARRIERS];
   logic                 ent_rel   [NUM_BARRIERS];
   logic                 ent_dup   [NUM_BARRIERS];
   logic                 ent_size  [NUM_BARRIERS];

   logic                 any_dup;
   logic                 any_size;

   assign req_ready = 1'b1;

   for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
      vx_barrier_unit_entry #(
         .NUM_WARPS (NUM_WARPS),
         .NW_BITS   (NW_BITS)
      ) u_entry (
         .clk         (clk),
         .reset       (reset),
         .sel         (req_valid && (req_id == NB_BITS'(g))),
         .req_wid     (req_wid),
         .req_size_m1 (req_size_m1),
         .req_noblock (req_noblock),
         .wait_mask   (ent_wait[g]),
         .rel_valid   (ent_rel[g]),
         .rel_wmask   (ent_rmask[g]),
         .err_dup     (ent_dup[g]),
         .err_size    (ent_size[g])
      );
   end

   // Merge slots: at most one slot releases or errors per cycle, so OR acts as the mux.
   always_comb begin
      stalled_wmask = '0;
      release_valid = 1'b0;
      release_wmask = '0;
      any_dup       = 1'b0;
      any_size      = 1'b0;
      for (int i = 0; i < NUM_BARRIERS; i++) begin
         stalled_wmask = stalled_wmask | ent_wait[i];
         release_valid = release_valid | ent_rel[i];
         release_wmask = release_wmask | ent_rmask[i];
         any_dup       = any_dup | ent_dup[i];
         any_size      = any_size | ent_size[i];
      end
   end

   // Error pulse one cycle after the offending request; a duplicate outranks a size mismatch.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_valid <= 1'b0;
         err_code  <= BAR_ERR_NONE;
      end else begin
         err_valid <= any_dup | any_size;
         err_code  <= any_dup ? BAR_ERR_DUP : (any_size ? BAR_ERR_SIZE : BAR_ERR_NONE);
      end
   end

`ifdef BARRIER_PERF_EN
   logic [NW_BITS:0] stall_pop;

   // Number of warps currently blocked.
   always_comb begin
      stall_pop = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         stall_pop = stall_pop + {{NW_BITS{1'b0}}, stalled_wmask[i]};
      end
   end

   // Free-running, wrapping counters of stalled warp-cycles and releases.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_releases     <= '0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + 64'(stall_pop);
         perf_releases     <= perf_releases + 32'(release_valid);
      end
   end
`endif

endmodule
